uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data byte width.
REQ-002 Parameter DEPTH, default 8: per-source FIFO depth; power of two, at least 2.
REQ-003 Parameter TAG_EN, default 1: when 1, each data byte is preceded by a tag byte.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port src_data, input, 3x WIDTH packed [2:0][WIDTH-1:0]: byte per source (0=raw RX, 1=MA, 2=FIR).
REQ-007 Port src_valid, input, 3: one-cycle strobe per source; src_data is valid in that cycle.
REQ-008 Port src_enable, input, 3: per-source enable (switch-driven, quasi-static).
REQ-009 Port tx_data, output, WIDTH: byte to UART TX.
REQ-010 Port tx_valid, output, 1: tx_data is valid; held until accepted.
REQ-011 Port tx_ready, input, 1: UART TX can accept a byte.
REQ-012 Port grant, output, 2: source currently being served; 2'd3 when idle.
REQ-013 Port drop_flags, output, 3: sticky per-source overflow flag.
REQ-014 Port drop_count, output, 16: total bytes dropped, all sources.

Function
REQ-015 Each source SHALL own a DEPTH-entry FIFO; a push occurs when src_valid[i] && src_enable[i].
REQ-016 A push to a full FIFO SHALL be accepted only if that FIFO pops in the same cycle; otherwise:
  - the byte is dropped
  - drop_flags[i] is set
  - drop_count increments, saturating at 16'hFFFF.
REQ-017 When src_enable[i] is 0, src_valid[i] SHALL be ignored and not counted; FIFO contents are retained, not flushed.
REQ-018 The FSM SHALL have states IDLE, TAG, DATA.
REQ-019 In IDLE, the arbiter SHALL choose the first non-empty, enabled source in round-robin order, starting after last_grant. It moves to TAG (TAG_EN=1) or DATA (TAG_EN=0). It stays in IDLE if no source is eligible.
REQ-020 In TAG, the outputs SHALL be tx_valid=1 and tx_data = 8'hA0 | source index. On tx_valid && tx_ready the FSM moves to DATA.
REQ-021 In DATA, the outputs SHALL be tx_valid=1 and tx_data = head of the granted FIFO. On tx_valid && tx_ready the FSM:
  - pops the FIFO
  - sets last_grant = granted source
  - returns to IDLE.
REQ-022 A transfer is exactly one cycle with tx_valid && tx_ready. tx_data and grant SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-023 tx_valid and tx_data SHALL be registered. From an empty, IDLE arbiter, tx_valid SHALL rise 2 cycles after the src_valid strobe.
REQ-024 Deasserting src_enable[g] of the granted source mid-transfer SHALL NOT abort the transfer; the TAG/DATA pair completes.
REQ-025 Simultaneous strobes on all three sources SHALL all be pushed; they are served in the order 0,1,2 after reset.
REQ-026 After serving source g, source g SHALL NOT be re-granted while another enabled source is non-empty (fairness).
REQ-027 grant SHALL show the granted index in TAG/DATA and 2'd3 in IDLE.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set:
  - FSM = IDLE
  - all FIFOs empty, with pointers and counts 0
  - tx_valid=0, tx_data=0
  - grant=2'd3
  - last_grant=2 (source 0 is served first)
  - drop_flags=0, drop_count=0
REQ-029 Reset asserted mid-transfer SHALL abandon the byte without a pop; tx_valid SHALL be 0 in the cycle after reset.

Structure
REQ-030 Package uart_arb_pkg SHALL hold:
  - the state enum (IDLE, TAG, DATA)
  - NUM_SRC=3
  - TAG_BASE=8'hA0
  - GRANT_NONE=2'd3
REQ-031 FIFO storage SHALL be a sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, head), instantiated three times.
REQ-032 The block SHALL contain no combinational path from tx_ready to tx_valid or tx_data.

Verification
REQ-033 Reset, TAG_EN=1, tx_ready=1, single strobe src 1 with 8'h5C -> tx_valid rises 2 cycles later; bytes sent are A1 then 5C; grant is 1 and then returns to 3.
REQ-034 Same-cycle strobes src0=11, src1=22, src2=33 -> byte sequence A0 11 A1 22 A2 33.
REQ-035 tx_ready held 0 for 20 cycles during DATA -> tx_valid stays 1 and tx_data stays constant; exactly one pop occurs after tx_ready rises.
REQ-036 tx_ready=0 and 10 strobes into src 2 with DEPTH=8 -> drop_count=2 and drop_flags=3'b100; the later drain sends the first 8 bytes in order.
REQ-037 src_enable=3'b101, strobes on all sources -> src 1 data is neither sent nor counted; src 0 and src 2 alternate.
REQ-038 rst pulsed while in TAG with tx_ready=0 -> next cycle tx_valid=0, FIFOs empty, drop_count=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the three-source UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned NUM_SRC    = 3;
  localparam logic [7:0]  TAG_BASE   = 8'hA0;
  localparam logic [1:0]  GRANT_NONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StTag,
    StData
  } arb_state_e;

  // Round-robin successor over the source indices 0..NUM_SRC-1.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'(NUM_SRC - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; a push into a full FIFO
// is taken only when the same cycle pops.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging three byte streams onto one UART TX port,
// optionally prefixing each byte with a source tag.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter bit          TAG_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0][WIDTH-1:0]     src_data,
  input  logic [2:0]                src_valid,
  input  logic [2:0]                src_enable,
  output logic [WIDTH-1:0]          tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [1:0]                grant,
  output logic [2:0]                drop_flags,
  output logic [15:0]               drop_count
);

  arb_state_e state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic             tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic [2:0]       drop_flags_q;
  logic [15:0]      drop_count_q, drop_count_d;

  logic [NUM_SRC-1:0]            push_req, push, pop, drop, full, empty, eligible;
  logic [NUM_SRC-1:0][WIDTH-1:0] head;
  logic [1:0]                    n_drop;
  logic [16:0]                   drop_sum;
  logic                          sel_found;
  logic [1:0]                    sel_idx, cand;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (src_data[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  assign eligible = ~empty & src_enable;
  assign push_req = src_valid & src_enable;
  assign drop     = push_req & full & ~pop;
  assign push     = push_req & ~drop;

  always_comb begin
    n_drop       = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    pop          = '0;
    sel_found    = 1'b0;
    sel_idx      = 2'd0;
    cand         = last_grant_q;

    // Search starts just after the last served source, so it is considered last.
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = rr_next(cand);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          grant_d    = sel_idx;
          tx_valid_d = 1'b1;
          if (TAG_EN) begin
            state_d   = StTag;
            tx_data_d = WIDTH'(TAG_BASE) | WIDTH'(sel_idx);
          end else begin
            state_d   = StData;
            tx_data_d = head[sel_idx];
          end
        end
      end
      StTag: begin
        if (tx_ready) begin
          state_d   = StData;
          tx_data_d = head[grant_q];
        end
      end
      StData: begin
        if (tx_ready) begin
          pop[grant_q] = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
          tx_valid_d   = 1'b0;
          grant_d      = GRANT_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= GRANT_NONE;
      last_grant_q <= 2'(NUM_SRC - 1);
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      drop_flags_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      drop_flags_q <= drop_flags_q | drop;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign drop_flags = drop_flags_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based transaction model checked every
// cycle, plus directed scenarios with literal expected byte sequences.
module tb_uart_tx_arbiter;

  localparam int D = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0][7:0] src_data;
  logic [2:0]      src_valid, src_enable;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant;
  logic [2:0]      drop_flags;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_enable (src_enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .drop_flags (drop_flags),
    .drop_count (drop_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: per-source queues, round-robin pick, drop accounting.
  logic [7:0] mq [3][$];
  logic [7:0] sent [$];
  logic [7:0] exp_q [$];
  int         m_last = 2;
  int         m_phase = 0;  // 0 none, 1 tag on the wire, 2 data on the wire
  int         m_cur = 0;
  int         m_cnt = 0;
  logic [2:0] m_flags = '0;
  bit         m_on = 1'b0;
  logic       p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
  logic [7:0] p_data = '0;
  logic [1:0] p_grant = 2'd3;
  logic [2:0] p_elig = '0;
  int         p_phase = 0;
  int         g;
  bit         m_pop;

  function automatic int rr_pick(input logic [2:0] el, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (el[c]) return c;
    end
    return 3;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      chk("drop_count", drop_count, m_cnt);
      chk("drop_flags", drop_flags, m_flags);
      if (p_rst) begin
        chk("rst_valid", tx_valid, 0);
        chk("rst_grant", grant, 3);
        chk("rst_data", tx_data, 0);
      end else if (p_valid && !p_ready) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, p_data);
        chk("hold_grant", grant, p_grant);
      end else if (!p_valid) begin
        if (p_elig != 0) begin
          g = rr_pick(p_elig, m_last);
          chk("arb_valid", tx_valid, 1);
          chk("arb_grant", grant, g);
          chk("arb_tag", tx_data, 8'hA0 | 8'(g));
          m_cur   = g;
          m_phase = 1;
        end else begin
          chk("idle_valid", tx_valid, 0);
          chk("idle_grant", grant, 3);
        end
      end else if (p_phase == 1) begin
        chk("data_valid", tx_valid, 1);
        chk("data_grant", grant, m_cur);
        chk("data_byte", tx_data, mq[m_cur][0]);
      end else begin
        chk("done_valid", tx_valid, 0);
        chk("done_grant", grant, 3);
      end
    end
    p_phase = m_phase;
    for (int i = 0; i < 3; i++) p_elig[i] = (mq[i].size() != 0) && src_enable[i];
    if (rst) begin
      m_on = 1'b1;
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_last = 2; m_phase = 0; m_cnt = 0; m_flags = '0;
    end else if (m_on) begin
      m_pop = 1'b0;
      if (tx_valid && tx_ready) begin
        sent.push_back(tx_data);
        if (m_phase == 1) begin
          m_phase = 2;
        end else if (m_phase == 2) begin
          void'(mq[m_cur].pop_front());
          m_last  = m_cur;
          m_phase = 0;
          m_pop   = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && src_enable[i]) begin
          if (mq[i].size() < D) begin
            mq[i].push_back(src_data[i]);
          end else begin
            m_flags[i] = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      end
    end
    p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data; p_grant = grant; p_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sent.delete();
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      done = (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0)
             && (m_phase == 0) && !tx_valid;
      if (done) break;
      tick();
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic chk_seq(input string name);
    chk({name, "_len"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      chk(name, sent[i], exp_q[i]);
    end
  endtask

  initial begin
    rst = 1'b1; src_data = '0; src_valid = '0; src_enable = 3'b111; tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sent.delete();

    // Single strobe on source 1: latency, tag, grant.
    src_data[1] = 8'h5C; src_valid = 3'b010;
    tick();
    src_valid = '0;
    chk("lat_early", tx_valid, 0);
    tick();
    chk("lat_rise", tx_valid, 1);
    chk("lat_grant", grant, 1);
    chk("lat_tag", tx_data, 8'hA1);
    drain(20);
    chk("t1_grant_idle", grant, 3);
    exp_q = '{8'hA1, 8'h5C};
    chk_seq("t1_seq");

    // Simultaneous strobes served 0,1,2 after reset.
    do_reset();
    src_data = {8'h33, 8'h22, 8'h11}; src_valid = 3'b111;
    tick();
    src_valid = '0;
    drain(40);
    exp_q = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33};
    chk_seq("t2_seq");

    // Backpressure during DATA.
    do_reset();
    tx_ready = 1'b0;
    src_data[0] = 8'h77; src_valid = 3'b001;
    tick();
    src_valid = '0;
    tick(); tick();
    chk("t3_tag", tx_data, 8'hA0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold_valid", tx_valid, 1);
      chk("t3_hold_data", tx_data, 8'h77);
    end
    tx_ready = 1'b1;
    drain(20);
    exp_q = '{8'hA0, 8'h77};
    chk_seq("t3_seq");

    // Overflow of source 2 with the sink stalled.
    do_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      src_data[2] = 8'h40 + 8'(k); src_valid = 3'b100;
      tick();
    end
    src_valid = '0;
    tick();
    chk("t4_drop_count", drop_count, 2);
    chk("t4_drop_flags", drop_flags, 3'b100);
    tx_ready = 1'b1;
    drain(100);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(8'hA2);
      exp_q.push_back(8'h40 + 8'(k));
    end
    chk_seq("t4_seq");

    // Source 1 disabled: ignored and uncounted; 0 and 2 alternate.
    do_reset();
    src_enable = 3'b101;
    src_data = {8'h03, 8'h02, 8'h01}; src_valid = 3'b111;
    tick();
    src_data = {8'h06, 8'h05, 8'h04};
    tick();
    src_valid = '0;
    drain(60);
    chk("t5_drop_count", drop_count, 0);
    exp_q = '{8'hA0, 8'h01, 8'hA2, 8'h03, 8'hA0, 8'h04, 8'hA2, 8'h06};
    chk_seq("t5_seq");
    src_enable = 3'b111;

    // Reset while stalled in TAG abandons the byte.
    do_reset();
    tx_ready = 1'b0;
    src_data[0] = 8'h99; src_valid = 3'b001;
    tick();
    src_valid = '0;
    tick(); tick();
    chk("t6_in_tag", tx_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid_low", tx_valid, 0);
    chk("t6_drop_count", drop_count, 0);
    sent.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_empty", tx_valid, 0);
    end
    chk("t6_sent", sent.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
